// File: rtl/fetch_buffer.sv
// Elastic fetch-to-decode instruction queue: circular buffer, in-order presentation, squash flush.
// Define FETCH_BUFFER_BYPASS_EN to forward in_packet straight to out_packet while the buffer is empty.
package fetch_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_packet_t;
endpackage

module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int DISP_W  = 2
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              squash,
    input  if_id_packet_t [FETCH_W-1:0]       in_packet,
    output logic                              in_ready,
    output if_id_packet_t [DISP_W-1:0]        out_packet,
    input  logic [$clog2(DISP_W+1)-1:0]       dispatch_num,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              empty,
    output logic                              full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    if_id_packet_t      mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    ptr_t               head_q, head_d;
    ptr_t               tail_q, tail_d;
    cnt_t               count_q, count_d;

    cnt_t               n_push, avail, pop_num, skip, store_pop;
    logic               prefix_gap;
    logic               bypass_act, push_ok;
    logic [FETCH_W-1:0] wr_en;
    ptr_t               wr_idx [FETCH_W];

    function automatic cnt_t min_cnt(input cnt_t a, input cnt_t b);
        return (a < b) ? a : b;
    endfunction

    // NOTE: every variable an always_comb writes gets a default first, so no path can infer a latch.
    always_comb begin
        prefix_gap = 1'b0;
        n_push     = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (!in_packet[i].valid) prefix_gap = 1'b1;
            if (!prefix_gap) n_push = n_push + cnt_t'(1);
        end
    end

    // Readiness looks only at registered occupancy; a pop this cycle does not help.
    assign in_ready = (DEPTH - int'(count_q)) >= FETCH_W;
    assign push_ok  = in_ready && !squash;

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass_act = (count_q == '0) && !squash;
`else
    assign bypass_act = 1'b0;
`endif

    // Bypassed lanes consumed by dispatch are skipped on write instead of being popped from storage.
    assign avail     = min_cnt(bypass_act ? n_push : count_q, cnt_t'(DISP_W));
    assign pop_num   = min_cnt(cnt_t'(dispatch_num), avail);
    assign skip      = bypass_act ? pop_num : '0;
    assign store_pop = bypass_act ? '0 : pop_num;

    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            wr_en[i]  = push_ok && (cnt_t'(i) < n_push) && (cnt_t'(i) >= skip);
            wr_idx[i] = tail_q + ptr_t'(cnt_t'(i) - skip);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end else begin
            for (int k = 0; k < DISP_W; k++) begin
                if (cnt_t'(k) < store_pop) valid_d[head_q + ptr_t'(k)] = 1'b0;
            end
            for (int i = 0; i < FETCH_W; i++) begin
                if (wr_en[i]) valid_d[wr_idx[i]] = 1'b1;
            end
            head_d  = head_q + ptr_t'(store_pop);
            if (push_ok) tail_d = tail_q + ptr_t'(n_push - skip);
            count_d = count_q + (push_ok ? n_push : '0) - skip - store_pop;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: the payload array has no reset; valid_q and count_q alone decide what is visible.
    always_ff @(posedge clock) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (wr_en[i]) mem_q[wr_idx[i]] <= in_packet[i];
        end
    end

    always_comb begin
        for (int j = 0; j < DISP_W; j++) begin
            out_packet[j]       = mem_q[head_q + ptr_t'(j)];
            out_packet[j].valid = valid_q[head_q + ptr_t'(j)] && (cnt_t'(j) < count_q);
`ifdef FETCH_BUFFER_BYPASS_EN
            if (bypass_act) begin
                if (j < FETCH_W) out_packet[j] = in_packet[j];
                else             out_packet[j] = '0;
                out_packet[j].valid = cnt_t'(j) < n_push;
            end
`endif
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == cnt_t'(DEPTH));

    // Dispatch may only consume lanes that are actually presented this cycle.
    a_dispatch_legal: assert property (@(posedge clock) disable iff (!reset_n)
        !squash |-> (cnt_t'(dispatch_num) <= avail));

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed table, latency/wrap sequences, randomized queue-model run.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int DEPTH   = 8;
    localparam int FETCH_W = 2;
    localparam int DISP_W  = 2;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                        clock = 1'b0;
    logic                        reset_n;
    logic                        squash;
    if_id_packet_t [FETCH_W-1:0] in_packet;
    logic                        in_ready;
    if_id_packet_t [DISP_W-1:0]  out_packet;
    logic [1:0]                  dispatch_num;
    logic [3:0]                  count;
    logic                        empty;
    logic                        full;

    int    n_cmp = 0;
    int    n_mis = 0;
    string phase = "reset";

    if_id_packet_t mq[$];

    typedef struct {
        bit          sq;
        bit          v0;
        logic [31:0] pc0;
        bit          v1;
        logic [31:0] pc1;
        int          dn;
        int          cnt;
        bit          rdy;
        bit          ov0;
        logic [31:0] opc0;
        bit          ov1;
        logic [31:0] opc1;
    } vec_t;

    vec_t vt[$];

    fetch_buffer #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .DISP_W(DISP_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .squash       (squash),
        .in_packet    (in_packet),
        .in_ready     (in_ready),
        .out_packet   (out_packet),
        .dispatch_num (dispatch_num),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL [%s] %s: got 0x%0h, want 0x%0h", phase, name, act, exp);
        end
    endtask

    function automatic if_id_packet_t mk(input bit v, input logic [31:0] pc);
        if_id_packet_t p;
        p.valid = v;
        p.pc    = pc;
        p.inst  = ~pc;
        return p;
    endfunction

    task automatic add_vec(input bit sq, input bit v0, input logic [31:0] pc0, input bit v1,
                           input logic [31:0] pc1, input int dn, input int cnt, input bit rdy,
                           input bit ov0, input logic [31:0] opc0, input bit ov1, input logic [31:0] opc1);
        vec_t v;
        v.sq = sq; v.v0 = v0; v.pc0 = pc0; v.v1 = v1; v.pc1 = pc1; v.dn = dn;
        v.cnt = cnt; v.rdy = rdy; v.ov0 = ov0; v.opc0 = opc0; v.ov1 = ov1; v.opc1 = opc1;
        vt.push_back(v);
    endtask

    task automatic drive(input bit sq, input if_id_packet_t p0, input if_id_packet_t p1, input int dn);
        @(negedge clock);
        squash       = sq;
        in_packet[0] = p0;
        in_packet[1] = p1;
        dispatch_num = 2'(dn);
        #1;
    endtask

    function automatic int prefix_len();
        int n;
        n = 0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (!in_packet[i].valid) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_check();
        int            sz;
        int            np;
        bit            byp;
        bit            ev;
        if_id_packet_t ep;
        sz  = mq.size();
        np  = prefix_len();
        byp = BYP && (sz == 0) && !squash;
        check("count", count, sz);
        check("in_ready", in_ready, (DEPTH - sz) >= FETCH_W);
        check("empty", empty, sz == 0);
        check("full", full, sz == DEPTH);
        for (int j = 0; j < DISP_W; j++) begin
            ev = byp ? (j < np) : (j < sz);
            ep = '0;
            if (ev) ep = byp ? in_packet[j] : mq[j];
            check($sformatf("lane%0d.valid", j), out_packet[j].valid, ev);
            if (ev) begin
                check($sformatf("lane%0d.pc", j), out_packet[j].pc, ep.pc);
                check($sformatf("lane%0d.inst", j), out_packet[j].inst, ep.inst);
            end
        end
    endtask

    task automatic model_update();
        int sz;
        int np;
        int dn;
        sz = mq.size();
        np = prefix_len();
        dn = int'(dispatch_num);
        if (squash) begin
            mq.delete();
        end else if (BYP && sz == 0) begin
            for (int i = dn; i < np; i++) mq.push_back(in_packet[i]);
        end else begin
            for (int k = 0; k < dn && mq.size() > 0; k++) void'(mq.pop_front());
            if ((DEPTH - sz) >= FETCH_W) begin
                for (int i = 0; i < np; i++) mq.push_back(in_packet[i]);
            end
        end
    endtask

    task automatic step(input bit sq, input if_id_packet_t p0, input if_id_packet_t p1, input int dn);
        drive(sq, p0, p1, dn);
        model_check();
        model_update();
    endtask

    initial begin
        int          vis;
        int          dn;
        int          np;
        bit          sq;
        bit          lane_chk;
        logic [31:0] pc;
        logic [31:0] exp_pop;
        if_id_packet_t p0, p1;

        reset_n      = 1'b0;
        squash       = 1'b0;
        in_packet    = '0;
        dispatch_num = '0;

        // Fill/drain, invalid-lane gap, squash mid-stream, then push after squash.
        //       sq v0 pc0     v1 pc1     dn cnt rdy ov0 opc0    ov1 opc1
        add_vec(0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 0, 32'h0,   0, 32'h0);
        add_vec(0, 1, 32'h00,  1, 32'h04,  0, 0, 1, 0, 32'h0,   0, 32'h0);
        add_vec(0, 1, 32'h08,  1, 32'h0C,  0, 2, 1, 1, 32'h00,  1, 32'h04);
        add_vec(0, 1, 32'h10,  1, 32'h14,  0, 4, 1, 1, 32'h00,  1, 32'h04);
        add_vec(0, 1, 32'h18,  1, 32'h1C,  0, 6, 1, 1, 32'h00,  1, 32'h04);
        add_vec(0, 0, 32'h0,   0, 32'h0,   0, 8, 0, 1, 32'h00,  1, 32'h04);
        add_vec(0, 1, 32'h20,  1, 32'h24,  2, 8, 0, 1, 32'h00,  1, 32'h04);
        add_vec(0, 0, 32'h0,   0, 32'h0,   2, 6, 1, 1, 32'h08,  1, 32'h0C);
        add_vec(0, 0, 32'h0,   0, 32'h0,   2, 4, 1, 1, 32'h10,  1, 32'h14);
        add_vec(0, 0, 32'h0,   0, 32'h0,   2, 2, 1, 1, 32'h18,  1, 32'h1C);
        add_vec(0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 0, 32'h0,   0, 32'h0);
        add_vec(0, 0, 32'h0,   1, 32'h30,  0, 0, 1, 0, 32'h0,   0, 32'h0);
        add_vec(0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 0, 32'h0,   0, 32'h0);
        add_vec(0, 1, 32'h200, 1, 32'h204, 0, 0, 1, 0, 32'h0,   0, 32'h0);
        add_vec(0, 1, 32'h208, 1, 32'h20C, 0, 2, 1, 1, 32'h200, 1, 32'h204);
        add_vec(0, 1, 32'h210, 0, 32'h0,   0, 4, 1, 1, 32'h200, 1, 32'h204);
        add_vec(1, 1, 32'h214, 1, 32'h218, 1, 5, 1, 1, 32'h200, 1, 32'h204);
        add_vec(0, 1, 32'h100, 0, 32'h0,   0, 0, 1, 0, 32'h0,   0, 32'h0);
        add_vec(0, 0, 32'h0,   0, 32'h0,   0, 1, 1, 1, 32'h100, 0, 32'h0);
        add_vec(0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 1, 32'h100, 0, 32'h0);
        add_vec(0, 0, 32'h0,   0, 32'h0,   0, 0, 1, 0, 32'h0,   0, 32'h0);

        #12;
        check("rst.count", count, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.empty", empty, 1);
        check("rst.full", full, 0);
        check("rst.lane0.valid", out_packet[0].valid, 0);
        check("rst.lane1.valid", out_packet[1].valid, 0);
        @(negedge clock);
        reset_n = 1'b1;

        phase = "table";
        foreach (vt[r]) begin
            drive(vt[r].sq, mk(vt[r].v0, vt[r].pc0), mk(vt[r].v1, vt[r].pc1), vt[r].dn);
            check($sformatf("r%0d.count", r), count, vt[r].cnt);
            check($sformatf("r%0d.in_ready", r), in_ready, vt[r].rdy);
            check($sformatf("r%0d.empty", r), empty, vt[r].cnt == 0);
            check($sformatf("r%0d.full", r), full, vt[r].cnt == DEPTH);
            lane_chk = !(BYP && vt[r].cnt == 0);
            if (lane_chk) begin
                check($sformatf("r%0d.lane0.valid", r), out_packet[0].valid, vt[r].ov0);
                if (vt[r].ov0) check($sformatf("r%0d.lane0.pc", r), out_packet[0].pc, vt[r].opc0);
                check($sformatf("r%0d.lane1.valid", r), out_packet[1].valid, vt[r].ov1);
                if (vt[r].ov1) check($sformatf("r%0d.lane1.pc", r), out_packet[1].pc, vt[r].opc1);
            end
            model_update();
        end

        phase = "latency";
`ifdef FETCH_BUFFER_BYPASS_EN
        drive(0, mk(1, 32'h40), mk(1, 32'h44), 1);
        check("lat.n.lane0.valid", out_packet[0].valid, 1);
        check("lat.n.lane0.pc", out_packet[0].pc, 32'h40);
        model_update();
        drive(0, '0, '0, 0);
        check("lat.n1.count", count, 1);
        check("lat.n1.lane0.valid", out_packet[0].valid, 1);
        check("lat.n1.lane0.pc", out_packet[0].pc, 32'h44);
`else
        drive(0, mk(1, 32'h40), mk(1, 32'h44), 0);
        check("lat.n.lane0.valid", out_packet[0].valid, 0);
        check("lat.n.lane1.valid", out_packet[1].valid, 0);
        model_update();
        drive(0, '0, '0, 0);
        check("lat.n1.count", count, 2);
        check("lat.n1.lane0.valid", out_packet[0].valid, 1);
        check("lat.n1.lane0.pc", out_packet[0].pc, 32'h40);
`endif
        model_update();
        step(1, '0, '0, 0);

        // Park head at entry 6, then push 2 / pop 1 across the 7 -> 0 boundary.
        phase = "wrap";
        step(0, mk(1, 32'h500), mk(1, 32'h504), 0);
        step(0, mk(1, 32'h508), mk(1, 32'h50C), 0);
        step(0, mk(1, 32'h510), mk(1, 32'h514), 0);
        step(0, '0, '0, 2);
        step(0, '0, '0, 2);
        step(0, '0, '0, 2);
        pc      = 32'h600;
        exp_pop = 32'h600;
        for (int c = 0; c < 12; c++) begin
            vis = (mq.size() > 0 || BYP) ? 1 : 0;
            drive(0, mk(1, pc), mk(1, pc + 32'h4), vis);
            model_check();
            if (vis == 1) begin
                check($sformatf("wrap.order%0d", c), out_packet[0].pc, exp_pop);
                exp_pop = exp_pop + 32'h4;
            end
            if ((DEPTH - mq.size()) >= FETCH_W) pc = pc + 32'h8;
            model_update();
        end

        phase = "random";
        pc = 32'h1000;
        for (int c = 0; c < 600; c++) begin
            sq       = ($urandom_range(0, 39) == 0);
            p0       = '0;
            p1       = '0;
            p0.valid = ($urandom_range(0, 3) != 0);
            p0.pc    = pc;
            p0.inst  = $urandom;
            p1.valid = ($urandom_range(0, 3) != 0);
            p1.pc    = pc + 32'h4;
            p1.inst  = $urandom;
            np  = p0.valid ? (p1.valid ? 2 : 1) : 0;
            vis = (BYP && mq.size() == 0 && !sq) ? np : mq.size();
            if (vis > DISP_W) vis = DISP_W;
            dn  = int'($urandom_range(0, vis));
            drive(sq, p0, p1, dn);
            model_check();
            if (!sq && (DEPTH - mq.size()) >= FETCH_W) pc = pc + 32'h8;
            model_update();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
